// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin, tenure-bounded sharing of the LED bank between requesters
// Optional idle heartbeat display enabled by defining LED_ARB_HEARTBEAT_EN.
module led_bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int TENURE = 1024,
  parameter int HB_W   = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] pat,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      leds,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TENURE);
  localparam logic [TW-1:0] TEN_MAX = TW'(TENURE - 1);

  if (NREQ < 2 || NREQ > 8 || TENURE < 2 || HB_W < WIDTH) begin : g_param_check
    $error("led_bank_arbiter: parameter out of range");
  end

  typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

  state_t             r_state;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_rr;
  logic [TW-1:0]      r_ten;
  logic [NREQ-1:0]    r_grant;
  logic [WIDTH-1:0]   r_leds;
  logic               r_busy;

  logic [NREQ-1:0]    w_others;
  logic               w_idle_hit;
  logic [IW-1:0]      w_idle_idx;
  logic               w_next_hit;
  logic [IW-1:0]      w_next_idx;
  logic               w_own_req;
  logic [WIDTH-1:0]   w_own_pat;
  logic [WIDTH-1:0]   w_idle_pat;
  logic [WIDTH-1:0]   w_next_pat;
  logic [WIDTH-1:0]   w_idle_leds;
  logic [IW-1:0]      w_owner_inc;
  logic               w_ten_full;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Two circular priority searches: from rr when idle, and from owner+1
  // (owner excluded, so it comes last) for release and preemption.
  always_comb begin
    w_others          = req;
    w_others[r_owner] = 1'b0;
    w_idle_hit        = 1'b0;
    w_idle_idx        = r_rr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_idle_hit && req[wrap_add(r_rr, k)]) begin
        w_idle_hit = 1'b1;
        w_idle_idx = wrap_add(r_rr, k);
      end
    end
    w_next_hit = 1'b0;
    w_next_idx = r_owner;
    for (int k = 1; k < NREQ; k++) begin
      if (!w_next_hit && w_others[wrap_add(r_owner, k)]) begin
        w_next_hit = 1'b1;
        w_next_idx = wrap_add(r_owner, k);
      end
    end
  end

  assign w_own_req   = req[r_owner];
  assign w_own_pat   = pat[int'(r_owner) * WIDTH +: WIDTH];
  assign w_idle_pat  = pat[int'(w_idle_idx) * WIDTH +: WIDTH];
  assign w_next_pat  = pat[int'(w_next_idx) * WIDTH +: WIDTH];
  assign w_owner_inc = wrap_add(r_owner, 1);
  assign w_ten_full  = (r_ten == TEN_MAX);

`ifdef LED_ARB_HEARTBEAT_EN
  logic [HB_W-1:0] r_hb;
  logic [HB_W-1:0] w_hb_next;

  assign w_hb_next   = r_hb + {{(HB_W-1){1'b0}}, 1'b1};
  // Idle display tracks the counter value written on the same edge.
  assign w_idle_leds = w_hb_next[HB_W-1 -: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hb <= '0;
    else        r_hb <= w_hb_next;
  end
`else
  assign w_idle_leds = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_ten   <= '0;
      r_grant <= '0;
      r_leds  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_idle_hit) begin
            r_state <= S_OWNED;
            r_owner <= w_idle_idx;
            r_grant <= onehot(w_idle_idx);
            r_busy  <= 1'b1;
            r_ten   <= '0;
            r_leds  <= w_idle_pat;
          end else begin
            r_leds  <= w_idle_leds;
          end
        end
        S_OWNED: begin
          if (!w_own_req) begin
            // Release wins over a coincident tenure expiry.
            r_rr <= w_owner_inc;
            if (w_next_hit) begin
              r_owner <= w_next_idx;
              r_grant <= onehot(w_next_idx);
              r_ten   <= '0;
              r_leds  <= w_next_pat;
            end else begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_ten   <= '0;
              r_leds  <= w_idle_leds;
            end
          end else if (w_ten_full && w_next_hit) begin
            r_owner <= w_next_idx;
            r_grant <= onehot(w_next_idx);
            r_ten   <= '0;
            r_leds  <= w_next_pat;
          end else begin
            if (!w_ten_full) r_ten <= r_ten + TW'(1);
            r_leds <= w_own_pat;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign leds  = r_leds;
  assign busy  = r_busy;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - randomized and directed bench for led_bank_arbiter against a reference model
module tb_led_bank_arbiter;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int TENURE = 8;
  localparam int HB_W   = 10;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] pat = '0;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      leds;
  logic                  busy;

  int checks = 0;
  int failures = 0;

  int m_owner = -1;
  int m_rr = 0;
  int m_age = 0;
  int m_cycles = 0;
  logic [NREQ-1:0]  exp_grant = '0;
  logic [WIDTH-1:0] exp_leds = '0;
  logic             exp_busy = 1'b0;

  led_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TENURE(TENURE), .HB_W(HB_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pat(pat),
    .grant(grant), .leds(leds), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input logic [NREQ-1:0] r, input int start, input int skip);
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (start + k) % NREQ;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] hb_leds();
`ifdef LED_ARB_HEARTBEAT_EN
    int v;
    v = (m_cycles % (1 << HB_W)) >> (HB_W - WIDTH);
    return WIDTH'(v);
`else
    return '0;
`endif
  endfunction

  function automatic int owner_of(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_rr = 0; m_age = 0; m_cycles = 0;
    exp_grant = '0; exp_leds = '0; exp_busy = 1'b0;
  endtask

  // Advance the model by one edge using the inputs now applied, then step the DUT.
  task automatic cycle();
    int n;
    m_cycles++;
    if (m_owner < 0) begin
      n = first_from(req, m_rr, -1);
      if (n >= 0) begin m_owner = n; m_age = 0; end
    end else if (!req[m_owner]) begin
      n = first_from(req, (m_owner + 1) % NREQ, m_owner);
      m_rr = (m_owner + 1) % NREQ;
      m_owner = n; m_age = 0;
    end else begin
      m_age++;
      n = first_from(req, (m_owner + 1) % NREQ, m_owner);
      if (m_age >= TENURE && n >= 0) begin m_owner = n; m_age = 0; end
    end
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    exp_busy = (m_owner >= 0);
    exp_leds = (m_owner >= 0) ? pat[m_owner*WIDTH +: WIDTH] : hb_leds();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    #1;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] want;
    req = 4'b0001;
    pat = NREQ*WIDTH'($urandom);
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
    if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds: got %h want 00", leds); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    req = '0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 4 || k == 8) begin
`ifdef LED_ARB_HEARTBEAT_EN
        want = (k == 4) ? 8'h01 : 8'h02;
`else
        want = 8'h00;
`endif
        checks++;
        if (leds !== want) begin failures++; $display("FAIL idle_leds k=%0d: got %h want %h", k, leds, want); end
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    pat[7:0] = 8'hA5;
    cycle();
    checks += 3;
    if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", grant); end
    if (leds !== 8'hA5) begin failures++; $display("FAIL single_leds: got %h want a5", leds); end
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
    pat[7:0] = 8'h3C;
    cycle();
    checks++;
    if (leds !== 8'h3C) begin failures++; $display("FAIL single_pat_change: got %h want 3c", leds); end
    req = 4'b0000;
    cycle();
    checks += 3;
    if (grant !== 4'b0000) begin failures++; $display("FAIL single_release: got %b want 0000", grant); end
    if (busy !== 1'b0) begin failures++; $display("FAIL single_release_busy: got %b want 0", busy); end
    if (leds !== exp_leds) begin failures++; $display("FAIL single_idle_leds: got %h want %h", leds, exp_leds); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5];
    int age;
    int prev;
    int cur;
    int gaps;
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    age = 0; prev = -1; gaps = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      req = '1;
      if (m_owner >= 0 && age == 2) req[m_owner] = 1'b0;
      pat = {$urandom, $urandom} >> 32;
      cycle();
      checks++;
      if (grant !== exp_grant) begin failures++; $display("FAIL rr_grant c=%0d: got %b want %b", c, grant, exp_grant); end
      if (prev >= 0 && busy !== 1'b1) gaps++;
      cur = owner_of(grant);
      if (cur != prev) begin order.push_back(cur); prev = cur; age = 0; end
      else age++;
    end
    checks++;
    if (order.size() < 5) begin
      failures++; $display("FAIL rr_count: got %0d grants want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]); end
      end
    end
    checks++;
    if (gaps != 0) begin failures++; $display("FAIL rr_gaps: got %0d idle cycles want 0", gaps); end
  endtask

  task automatic test_preemption();
    logic [NREQ-1:0] want;
    do_reset();
    req = 4'b0001;
    cycle();
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL pre_grant0: got %b want 0001", grant); end
    for (int k = 1; k <= TENURE; k++) begin
      if (k == 3) req = 4'b0101;
      pat = NREQ*WIDTH'($urandom);
      cycle();
      want = (k < TENURE) ? 4'b0001 : 4'b0100;
      checks += 2;
      if (grant !== want) begin failures++; $display("FAIL pre_to2 k=%0d: got %b want %b", k, grant, want); end
      if (leds !== exp_leds) begin failures++; $display("FAIL pre_leds k=%0d: got %h want %h", k, leds, exp_leds); end
    end
    for (int k = 1; k <= TENURE; k++) begin
      cycle();
      want = (k < TENURE) ? 4'b0100 : 4'b0001;
      checks++;
      if (grant !== want) begin failures++; $display("FAIL pre_back0 k=%0d: got %b want %b", k, grant, want); end
    end
  endtask

  task automatic test_no_contention();
    logic [WIDTH-1:0] p1;
    req = 4'b0010;
    for (int c = 0; c < 50; c++) begin
      pat = NREQ*WIDTH'($urandom);
      p1 = pat[15:8];
      cycle();
      checks += 2;
      if (grant !== 4'b0010) begin failures++; $display("FAIL nocont_grant c=%0d: got %b want 0010", c, grant); end
      if (leds !== p1) begin failures++; $display("FAIL nocont_leds c=%0d: got %h want %h", c, leds, p1); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0010;
    pat = NREQ*WIDTH'($urandom);
    cycle();
    for (int k = 1; k < TENURE; k++) begin
      req = 4'b1010;
      cycle();
      checks++;
      if (grant !== 4'b0010) begin failures++; $display("FAIL sim_hold k=%0d: got %b want 0010", k, grant); end
    end
    req = 4'b1000;
    cycle();
    checks += 3;
    if (grant !== 4'b1000) begin failures++; $display("FAIL sim_handoff: got %b want 1000", grant); end
    if (grant !== exp_grant) begin failures++; $display("FAIL sim_model: got %b want %b", grant, exp_grant); end
    if (leds !== pat[31:24]) begin failures++; $display("FAIL sim_leds: got %h want %h", leds, pat[31:24]); end
    req = 4'b0001;
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (grant !== 4'b0000) begin failures++; $display("FAIL sim_rst_grant: got %b want 0000", grant); end
    if (leds !== 8'h00) begin failures++; $display("FAIL sim_rst_leds: got %h want 00", leds); end
    if (busy !== 1'b0) begin failures++; $display("FAIL sim_rst_busy: got %b want 0", busy); end
    m_reset();
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL sim_rst_held: got %b want 0000", grant); end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1010;
    cycle();
    checks++;
    if (grant !== 4'b0010) begin failures++; $display("FAIL sim_after_rst: got %b want 0010", grant); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = req;
      for (int i = 0; i < NREQ; i++) begin
        if (r[i]) r[i] = ($urandom_range(0, 99) < 88);
        else      r[i] = ($urandom_range(0, 99) < 20);
      end
      req = r;
      pat = NREQ*WIDTH'($urandom);
      cycle();
      checks += 3;
      if (grant !== exp_grant) begin failures++; $display("FAIL rand_grant c=%0d: got %b want %b", c, grant, exp_grant); end
      if (leds !== exp_leds) begin failures++; $display("FAIL rand_leds c=%0d: got %h want %h", c, leds, exp_leds); end
      if (busy !== exp_busy) begin failures++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, exp_busy); end
    end
  endtask

  initial begin
    m_reset();
    #1;
    checks++;
    if (grant !== 4'b0000 || leds !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL por_outputs: got grant=%b leds=%h busy=%b want 0000/00/0", grant, leds, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_preemption();
    test_no_contention();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
# led_bank_arbiter

Shares the board's 8-LED output bank between several on-chip requesters, with round-robin fairness and a bounded tenure per grant. Sits between the requesting logic and the LED output buffers: its `leds` bus drives the eight LED output pads directly. When no requester holds the bank, it optionally shows a free-running heartbeat count so the board visibly stays alive.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: LED bank width.
- `TENURE`, 1024: cycles an owner may hold the bank while others wait, at least 2.
- `HB_W`, 26: heartbeat counter width, at least WIDTH; used only with the heartbeat option.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: per-requester request level; held high while the bank is wanted.
- `pat`  in  NREQ*WIDTH: per-requester LED pattern; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `grant`  out  NREQ: one-hot owner indication, all zeros when idle; registered.
- `leds`  out  WIDTH: LED bank drive; registered.
- `busy`  out  1: high while any grant is active; registered; equals OR of `grant`.

## Operation
- States: IDLE and OWNED. Internal registers: owner index, round-robin pointer `rr`, tenure counter `ten`.
- **IDLE:**
  - If `req` != 0, select the first asserted requester searching `rr`, `rr`+1, … modulo NREQ.
  - Go to OWNED, one-hot `grant` for that requester, `ten` = 0.
- **OWNED, owner's `req` low (release):**
  - If another request is pending, grant it directly with the search starting at owner+1, `ten` = 0.
  - Otherwise go to IDLE with `grant` = 0.
  - In both cases `rr` = old owner+1.
- **OWNED, owner's `req` high:**
  - `ten` increments and saturates at TENURE-1.
  - If `ten` == TENURE-1 and any other `req` is high (preemption), hand the grant to the next requester searching from owner+1. The old owner is last in that search.
  - If no other `req` is high, the owner keeps the grant indefinitely.
- `rr` wraps from NREQ-1 to 0.
- **`leds`:**
  - OWNED: `leds` = owner's `pat` sampled every cycle.
  - IDLE: heartbeat display, see Configuration.
- Simultaneous release and preemption on the same edge are treated as a release.
- Reset mid-grant is asynchronous. `grant`, `leds`, `busy`, `ten`, `rr` and the heartbeat counter all go to 0 immediately. After reset release, arbitration restarts from requester 0.

## Timing
- Request to grant: `req` high sampled at edge t gives `grant` and `busy` high after edge t. `leds` shows that requester's `pat` sampled at edge t on the same edge.
- `pat` to `leds` latency is 1 cycle while owned.
- Release: `req` low sampled at edge t deasserts `grant` after edge t. There are no dead cycles on a direct handoff.
- Preemption occurs on the edge where the old owner has held the grant for TENURE cycles, i.e. the TENURE-th edge after its grant edge.
- Outputs are glitch-free: all are direct register outputs.
- Reset values: `grant` = 0, `leds` = 0, `busy` = 0.

## Configuration
- Macro: `LED_ARB_HEARTBEAT_EN`.
- **Defined:**
  - A HB_W-bit counter increments every cycle from reset and wraps modulo 2^HB_W.
  - In IDLE, `leds` = counter bits `[HB_W-1 : HB_W-WIDTH]`, registered.
  - The counter keeps running during OWNED.
- **Undefined:** no heartbeat counter is synthesized; `leds` = 0 in IDLE.

## Test plan
- **Reset and idle:**
  - Assert `rst_n` = 0 mid-run → `grant` = 0, `leds` = 0, `busy` = 0 asynchronously.
  - With the macro and HB_W = 10, WIDTH = 8: `leds` steps to 0x01 after 4 cycles and 0x02 after 8 cycles.
  - Without the macro, `leds` stays 0x00.
- **Single requester:** `req` = 0001, pat0 = 0xA5 → `grant` = 0001 and `leds` = 0xA5 one cycle later; pat0 changes to 0x3C → `leds` = 0x3C next cycle; drop `req` → `grant` = 0 next cycle.
- **Round-robin:**
  - All `req` = 1111, each requester releasing after 3 cycles of ownership and re-requesting immediately.
  - Required grant order: 0, 1, 2, 3, 0, each handoff with no idle cycle.
- **Preemption:**
  - TENURE = 8: req0 held forever; req2 raised 2 cycles after grant0.
  - → `grant` switches to 0100 exactly 8 cycles after the grant0 edge.
  - req2 then also held → grant returns to 0001 after 8 more cycles.
- **No contention:** TENURE = 8, only req1 held for 50 cycles → `grant` stays 0010 throughout; `ten` saturates without any handoff.
- **Simultaneous events:**
  - Owner releases on the same edge its tenure expires, with req3 pending → handoff to requester 3 as a release, `rr` = owner+1.
  - Reset asserted during the handoff → all outputs 0; after reset, `req` = 1010 grants requester 1 first.
